scan_divider: RTL
=================

SCAN_DIVIDER -- requirements
Module: scan_divider

Interface
REQ-001 Parameter CNT_W, default 15, SHALL set the prescale counter and terminal-count width.
REQ-002 Parameter DEF_TC, default 31250, SHALL set the terminal count loaded at reset; the prescale period is DEF_TC+1 cycles.
REQ-003 Parameter DIGITS, default 4, range 2..16, SHALL set the number of scanned display digits.
REQ-004 Parameter SEL_W, default 2, SHALL set the digit_sel width and SHALL satisfy 2**SEL_W >= DIGITS.
REQ-005 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port en, input, 1 bit: count enable.
REQ-009 Port tc_load, input, 1 bit: one-cycle strobe that loads the terminal count.
REQ-010 Port tc_in, input, CNT_W bits: new terminal count, sampled when tc_load is high.
REQ-011 Port count, output, CNT_W bits: the prescale counter value.
REQ-012 Port tick, output, 1 bit: registered one-cycle pulse, asserted once per prescale period.
REQ-013 Port digit_sel, output, SEL_W bits: index of the active digit.
REQ-014 Port anode, output, DIGITS bits: active-low one-hot digit enable.
REQ-015 Port frame, output, 1 bit: registered one-cycle pulse, asserted when the digit scan wraps.

Function
REQ-016 The internal register tc SHALL hold the active terminal count.
REQ-017 A wrap SHALL be defined as: en=1 and count==tc and tc_load=0.
REQ-018 On a wrap, count SHALL become 0 at the next edge; otherwise, when en=1, count SHALL increment by 1 (count sequence 0..tc inclusive).
REQ-019 When en=0, count, digit_sel and tc SHALL hold, and tick and frame SHALL be 0 at the next edge; tc_load still SHALL act.
REQ-020 When tc_load=1, tc SHALL take tc_in and count SHALL become 0 at the next edge, regardless of en.
REQ-021 When tc_load=1, no tick and no digit advance SHALL occur on that edge; tc_load SHALL take priority over a coincident wrap.
REQ-022 tick SHALL be 1 exactly in the cycle following a wrap (while count==0), and 0 otherwise.
REQ-023 With tc==0 and en held high, tick SHALL be 1 every cycle from the second enabled edge onward.
REQ-024 On each wrap, digit_sel SHALL advance by 1, with DIGITS-1 going to 0.
REQ-025 digit_sel SHALL never take a value >= DIGITS.
REQ-026 frame SHALL be 1 in the cycle following a wrap where digit_sel went from DIGITS-1 to 0, and 0 otherwise.
REQ-027 anode SHALL equal the bitwise inverse of (1 << digit_sel) at all times, driven from registered state with no glitch path from inputs.
REQ-028 All arithmetic SHALL be unsigned modulo 2**CNT_W.
REQ-029 count SHALL never exceed tc, because every tc change also clears count.

Reset
REQ-030 While rst_n=0, outputs SHALL immediately and asynchronously take: count=0, tc=DEF_TC, tick=0, frame=0, digit_sel=0, anode=all ones except bit0=0.
REQ-031 Reset asserted mid-period or mid-scan SHALL discard all progress, including any previously loaded tc.
REQ-032 After rst_n deasserts, the first count increment SHALL occur on the first rising edge with en=1.

Verification (bench parameters CNT_W=4, DEF_TC=3, DIGITS=4)
REQ-033 Reset release, en=1 for 20 cycles -> count 0,1,2,3,0,... with tick high 1 cycle every 4 cycles while count==0, digit_sel 1,2,3,0, and frame high once, coincident with digit_sel returning to 0.
REQ-034 tc_in=5 with tc_load pulsed at count==2 -> count 0 next, then tick period is 6 cycles; no tick on the load edge.
REQ-035 tc_load pulsed on the wrap cycle (count==3) -> tick stays 0, digit_sel does not advance, count=0.
REQ-036 en dropped at count==2 for 5 cycles -> count holds at 2, tick=0, anode unchanged; the wrap occurs 2 enabled cycles after en returns.
REQ-037 tc_in=0 loaded, en=1 -> tick continuously high from the second edge, digit_sel advances every cycle, frame high every 4 cycles.
REQ-038 rst_n pulsed low asynchronously between edges at count==2, digit_sel==2 -> count=0, digit_sel=0, anode=4'b1110 and tc restored to 3 before the next edge.

Source files
------------

// File: rtl/scan_divider.sv
// Prescaled display-scan divider: a programmable prescale counter emits a tick
// each period and steps an active-low one-hot digit select; frame marks each full scan.
module scan_divider #(
  parameter int CNT_W  = 15,
  parameter int DEF_TC = 31250,
  parameter int DIGITS = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tc_load,
  input  logic [CNT_W-1:0]  tc_in,
  output logic [CNT_W-1:0]  count,
  output logic              tick,
  output logic [SEL_W-1:0]  digit_sel,
  output logic [DIGITS-1:0] anode,
  output logic              frame
);

  localparam logic [CNT_W-1:0] TC_RESET = CNT_W'(DEF_TC);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             frame_q, frame_d;
  logic             wrap;

  // A load always wins over a coincident wrap, so wrap excludes tc_load.
  always_comb begin
    wrap = en && !tc_load && (count_q == tc_q);
  end

  always_comb begin
    count_d = count_q;
    tc_d    = tc_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    frame_d = 1'b0;
    if (tc_load) begin
      tc_d    = tc_in;
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
      tick_d  = 1'b1;
      frame_d = (sel_q == LAST_SEL);
      sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= TC_RESET;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  // Anodes decode only the registered select, so they cannot glitch on inputs.
  for (genvar i = 0; i < DIGITS; i++) begin : g_anode
    assign anode[i] = (sel_q != SEL_W'(i));
  end

  assign count     = count_q;
  assign tick      = tick_q;
  assign frame     = frame_q;
  assign digit_sel = sel_q;

endmodule
